jk_button_driver: RTL and testbench

- Upstream command stage for the JK flip-flop.
- Converts two raw, asynchronous, bouncing pushbuttons (SET, CLR) into clean one-cycle J/K command pulses on the same clock as the flip-flop.
- Each button gets its own 2-FF synchronizer and debounce filter.
- A small FSM merges near-simultaneous presses into a toggle command (J=K=1).
- Outputs connect directly to the flip-flop's J and K inputs. Idle output is J=K=0, which is the flip-flop's hold state.

---
 rtl/jk_button_driver.sv | 132 +++++++++++++
 tb/tb_jk_button_driver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_button_driver.sv
// rtl/jk_button_driver.sv - SET/CLR pushbutton front end producing one-cycle J/K command pulses
module jk_button_driver #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int COMBINE_CYCLES  = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_set,
  input  logic i_btn_clr,
  output logic o_j,
  output logic o_k,
  output logic o_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WC_W  = $clog2(COMBINE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(COMBINE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_K, WAIT_J, EMIT, HOLD} state_t;

  // bit 0 carries SET, bit 1 carries CLR through the whole input path
  logic [1:0]       raw;
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [1:0]       ev;
  logic [CNT_W-1:0] cnt [2];

  state_t          state, state_nxt;
  logic [WC_W-1:0] wc, wc_nxt;
  logic            j_nxt, k_nxt;

  assign raw = {i_btn_clr, i_btn_set};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= '0;
      sync <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev = db & ~db_d;

  always_comb begin
    state_nxt = state;
    wc_nxt    = wc;
    j_nxt     = 1'b0;
    k_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (ev == 2'b11) begin
          state_nxt = EMIT;
          j_nxt     = 1'b1;
          k_nxt     = 1'b1;
        end else if (ev[0]) begin
          state_nxt = WAIT_K;
          wc_nxt    = '0;
        end else if (ev[1]) begin
          state_nxt = WAIT_J;
          wc_nxt    = '0;
        end
      end
      // a second press on the timeout cycle still upgrades to toggle
      WAIT_K: begin
        if (ev[1]) begin
          state_nxt = EMIT;
          j_nxt     = 1'b1;
          k_nxt     = 1'b1;
        end else if (wc == WC_MAX) begin
          state_nxt = EMIT;
          j_nxt     = 1'b1;
        end else begin
          wc_nxt = wc + 1'b1;
        end
      end
      WAIT_J: begin
        if (ev[0]) begin
          state_nxt = EMIT;
          j_nxt     = 1'b1;
          k_nxt     = 1'b1;
        end else if (wc == WC_MAX) begin
          state_nxt = EMIT;
          k_nxt     = 1'b1;
        end else begin
          wc_nxt = wc + 1'b1;
        end
      end
      EMIT: state_nxt = HOLD;
      HOLD: begin
        if (db == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // J/K are registered from the next-state decode so the pulse lines up with EMIT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      wc    <= '0;
      o_j   <= 1'b0;
      o_k   <= 1'b0;
    end else begin
      state <= state_nxt;
      wc    <= wc_nxt;
      o_j   <= j_nxt;
      o_k   <= k_nxt;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_jk_button_driver.sv
// tb/tb_jk_button_driver.sv - randomized and directed checks of jk_button_driver against a timestamp-based model
module tb_jk_button_driver;

  localparam int D = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_set = 1'b0;
  logic btn_clr = 1'b0;
  logic o_j, o_k, o_busy;

  jk_button_driver #(.DEBOUNCE_CYCLES(D), .COMBINE_CYCLES(C)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_set(btn_set), .i_btn_clr(btn_clr),
    .o_j(o_j), .o_k(o_k), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model: raw history, run lengths of disagreement, press timestamps
  bit [1:0] m_meta, m_s, m_db, m_dbd;
  int m_run [2];
  int mode;     // 0 idle, 1 waiting for partner press, 2 emitting, 3 holding
  int pkind;    // 0 = SET first, 1 = CLR first
  int pstart;
  int now = 0;
  bit exp_j, exp_k, exp_busy;

  // per-scenario observations of the DUT
  int t0, cnt_j, cnt_k, cnt_t, first_j, first_t, busy_seen;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, now);
    end
  endtask

  task automatic model_step(input bit rs, input bit rc, input bit r);
    bit [1:0] ev, db_old;
    now++;
    exp_j = 0;
    exp_k = 0;
    if (r) begin
      m_meta = 0; m_s = 0; m_db = 0; m_dbd = 0;
      m_run[0] = 0; m_run[1] = 0;
      mode = 0;
      exp_busy = 0;
      return;
    end
    db_old = m_db;
    ev = m_db & ~m_dbd;
    case (mode)
      0: begin
        if (ev == 2'b11) begin exp_j = 1; exp_k = 1; mode = 2; end
        else if (ev[0]) begin mode = 1; pkind = 0; pstart = now; end
        else if (ev[1]) begin mode = 1; pkind = 1; pstart = now; end
      end
      1: begin
        if (ev[1-pkind]) begin exp_j = 1; exp_k = 1; mode = 2; end
        else if (now - pstart == C) begin
          exp_j = (pkind == 0);
          exp_k = (pkind == 1);
          mode = 2;
        end
      end
      2: mode = 3;
      default: if (db_old == 0) mode = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (m_s[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin m_db[i] = m_s[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_dbd = db_old;
    m_s = m_meta;
    m_meta = {rc, rs};
    exp_busy = (mode != 0);
  endtask

  // the single compare point: one edge, then model vs DUT on the falling edge
  task automatic tick();
    int rel;
    @(posedge clk);
    model_step(btn_set, btn_clr, rst);
    @(negedge clk);
    check("o_j", o_j, exp_j);
    check("o_k", o_k, exp_k);
    check("o_busy", o_busy, exp_busy);
    rel = now - t0 - 1;
    if (o_j && !o_k) begin cnt_j++; if (first_j < 0) first_j = rel; end
    if (!o_j && o_k) cnt_k++;
    if (o_j && o_k) begin cnt_t++; if (first_t < 0) first_t = rel; end
    if (o_busy) busy_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_scenario();
    t0 = now;
    cnt_j = 0; cnt_k = 0; cnt_t = 0;
    first_j = -1; first_t = -1; busy_seen = 0;
  endtask

  task automatic release_and_settle();
    btn_set = 0;
    btn_clr = 0;
    ticks(30);
    check("settled_idle", o_busy, 0);
  endtask

  int rem [2];
  bit lvl [2];

  initial begin
    // reset held 3 cycles with both buttons down, then a single toggle
    rst = 1; btn_set = 1; btn_clr = 1;
    start_scenario();
    ticks(3);
    check("reset_no_pulse", cnt_j + cnt_k + cnt_t, 0);
    check("reset_busy", busy_seen, 0);
    rst = 0;
    start_scenario();
    ticks(25);
    check("post_reset_toggle_count", cnt_t, 1);
    check("post_reset_single_count", cnt_j + cnt_k, 0);
    // both debounce together: ev on edge 10, pulse visible after edge 10
    check("post_reset_toggle_edge", first_t, 10);
    release_and_settle();

    // clean SET press: ev on edge 10, pulse registered at edge 14 (seen at cycle 15)
    start_scenario();
    btn_set = 1;
    ticks(40);
    check("clean_set_j_count", cnt_j, 1);
    check("clean_set_j_edge", first_j, 14);
    check("clean_set_other", cnt_k + cnt_t, 0);
    release_and_settle();

    // bounce shorter than the debounce window never registers
    start_scenario();
    for (int i = 0; i < 30; i++) begin
      btn_set = ((i / 3) % 2) == 1;
      tick();
    end
    btn_set = 0;
    ticks(20);
    check("bounce_pulses", cnt_j + cnt_k + cnt_t, 0);
    check("bounce_busy", busy_seen, 0);

    // CLR two cycles after SET: toggle one cycle after ev_clr (edge 12)
    start_scenario();
    btn_set = 1;
    ticks(2);
    btn_clr = 1;
    ticks(30);
    check("near_toggle_count", cnt_t, 1);
    check("near_toggle_edge", first_t, 12);
    check("near_single_count", cnt_j + cnt_k, 0);
    release_and_settle();

    // CLR ten cycles after SET: only the J pulse, CLR lost in HOLD
    start_scenario();
    btn_set = 1;
    ticks(10);
    btn_clr = 1;
    ticks(30);
    check("outside_j_count", cnt_j, 1);
    check("outside_j_edge", first_j, 14);
    check("outside_other", cnt_k + cnt_t, 0);
    release_and_settle();
    start_scenario();
    btn_clr = 1;
    ticks(30);
    check("fresh_clr_k_count", cnt_k, 1);
    check("fresh_clr_other", cnt_j + cnt_t, 0);
    release_and_settle();

    // reset while waiting for a partner press
    start_scenario();
    btn_set = 1;
    ticks(11);
    btn_set = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    check("rst_wait_busy", o_busy, 0);
    ticks(25);
    check("rst_wait_pulses", cnt_j + cnt_k + cnt_t, 0);

    // random hold lengths around the debounce and combine windows
    for (int it = 0; it < 12; it++) begin
      rem[0] = 0; rem[1] = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
        for (int b = 0; b < 2; b++) begin
          if (rem[b] == 0) begin
            lvl[b] = $urandom_range(0, 1) == 1;
            rem[b] = (it % 2 == 0) ? $urandom_range(1, 14) : $urandom_range(6, 30);
          end
          rem[b]--;
        end
        btn_set = lvl[0];
        btn_clr = lvl[1];
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 0;
      release_and_settle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
